dl_demux8_buf: RTL and testbench
================================

# dl_demux8_buf

Parameterized 1-to-8 stream demultiplexer with one buffered entry per output. It accepts a single valid/ready input stream and steers each message, by a 3-bit destination field, into one of eight registered output streams. It is the distribution-side counterpart to the 8-to-1 selector in the design library, used to fan results out to eight consumers such as writeback ports or per-unit queues. Messages aimed at disabled ports are dropped and counted.

## Interface
Parameters:
- NUM_BITS, 32, message width in bits
- CNT_BITS, 16, width of the drop counter

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_val  input  1  input message valid
- in_rdy  output  1  input ready
- in_msg  input  NUM_BITS  input payload
- in_dest  input  3  destination port index, 0..7
- port_en  input  8  per-port enable; a 0 bit makes that port a drop target
- out_val  output  8  per-port output valid; bit i belongs to port i
- out_rdy  input  8  per-port consumer ready
- out_msg  output  8*NUM_BITS  packed payloads; port i occupies bits [i*NUM_BITS +: NUM_BITS]
- drop_cnt  output  CNT_BITS  number of dropped messages, saturating

## Operation
- Each port i has one entry: a valid flag v[i] and a data register d[i].
  - out_val[i] = v[i]
  - out_msg slice i = d[i]
- Port i is free when v[i] == 0 or out_rdy[i] == 1 (its entry drains this cycle).
- in_rdy behaviour:
  - If port_en[in_dest] == 1: in_rdy = free(in_dest).
  - If port_en[in_dest] == 0: in_rdy = 1 (drop path is always ready).
  - in_rdy is combinational from in_dest, port_en, out_rdy and v; it has no dependence on in_val.
- A transfer occurs when in_val && in_rdy.
  - Enabled destination: d[in_dest] <= in_msg and v[in_dest] <= 1.
  - Disabled destination: no entry changes; drop_cnt increments.
- A port drain occurs when v[i] && out_rdy[i]. It clears v[i] unless the same cycle also writes a new message into port i.
- A simultaneous drain and fill on the same port gives 100% throughput: v stays 1 and d takes the new message.
- Drains on the other seven ports proceed independently in the same cycle.
- drop_cnt saturates at 2^CNT_BITS-1 and never wraps.
- port_en is sampled only with the transfer. Clearing port_en[i] while v[i] == 1 does not flush the entry; it still drains normally.
- out_rdy[i] while v[i] == 0 has no effect.
- Holding rules:
  - The producer keeps in_msg and in_dest stable while in_val && !in_rdy.
  - The bench checks that out_msg slice i is stable while out_val[i] && !out_rdy[i].

## Timing
- Latency: a message accepted at edge N is visible on out_val and out_msg at port in_dest immediately after edge N (1 cycle).
- Peak throughput is one message per cycle. It is sustained to a single port only while that consumer holds out_rdy = 1.
- Reset state, in effect asynchronously while rst_n == 0:
  - v = 8'h00, so out_val = 0
  - d = 0, so out_msg = 0
  - drop_cnt = 0
  - in_rdy then follows the combinational rule: 1 for any destination, since all entries are empty.
- A reset asserted mid-operation discards all buffered messages without emitting them. The first edge after rst_n deasserts may accept a message.
- There are no combinational paths from in_val to any output, and none from in_msg to any output.

## Structure
- Shared package dl_pkg: localparam DL_NUM_PORTS = 8 and typedef logic [2:0] dl_port_id_t. in_dest is typed dl_port_id_t.
- Sub-module dl_buf1: a one-entry valid/ready register (NUM_BITS parameter, enq/deq handshake, async active-low reset), instantiated 8 times.
- The top level holds the destination decode, the in_rdy select, and the saturating drop counter.

## Test plan
- Reset: hold rst_n = 0 with in_val = 1 -> out_val = 8'h00, drop_cnt = 0, no transfer. After release, send 32'hA5A5_0003 to dest 3 -> out_val = 8'h08 next cycle, slice 3 = 32'hA5A5_0003.
- Backpressure: with out_rdy[5] = 0, send to dest 5 twice -> first accepted; second sees in_rdy = 0 and is held. Raise out_rdy[5] -> first drains and second is accepted in the same cycle; slice 5 updates with no bubble.
- Streaming: all out_rdy = 8'hFF, send messages 0..15 with dest = i%8 back-to-back -> in_rdy is 1 every cycle and each port receives its two messages in order.
- Drop: port_en = 8'hFE, send 3 messages to dest 0 -> in_rdy = 1, out_val[0] stays 0, drop_cnt = 3. With CNT_BITS = 2, send 5 drops -> drop_cnt saturates at 3.
- Independence: fill ports 1 and 6 with out_rdy = 0, then drain port 1 only -> out_val goes 8'h42 -> 8'h40; a new message to dest 1 is accepted while port 6 stays held.
- Mid-operation reset: 4 ports occupied, assert rst_n = 0 between edges -> out_val = 0 immediately, before the next clock edge; no stale data appears after release.

Source files
------------

// File: rtl/dl_pkg.sv
// Shared definitions for the dl_* distribution blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dl_pkg;

  localparam int DL_NUM_PORTS = 8;

  typedef logic [2:0] dl_port_id_t;

endpackage

// File: rtl/dl_demux8_buf_if.sv
// Stream bundle for the 1-to-8 demux: one input stream plus eight output streams.
// Latency: n/a (wiring only).
// Backpressure: in_rdy from the demux, out_rdy per port from the consumers.
// Ports: in_val/in_rdy/in_msg/in_dest (producer side), out_val/out_rdy/out_msg (consumer side).
interface dl_demux8_buf_if
  import dl_pkg::*;
#(
  parameter int NUM_BITS = 32
);

  logic                             in_val;
  logic                             in_rdy;
  logic [NUM_BITS-1:0]              in_msg;
  dl_port_id_t                      in_dest;
  logic [DL_NUM_PORTS-1:0]          out_val;
  logic [DL_NUM_PORTS-1:0]          out_rdy;
  logic [DL_NUM_PORTS*NUM_BITS-1:0] out_msg;

  // master drives the producer side and consumes the outputs
  modport master (
    output in_val, in_msg, in_dest, out_rdy,
    input  in_rdy, out_val, out_msg
  );

  // slave is the demux itself
  modport slave (
    input  in_val, in_msg, in_dest, out_rdy,
    output in_rdy, out_val, out_msg
  );

endinterface

// File: rtl/dl_buf1.sv
// One-entry valid/ready register slice.
// Latency: 1 cycle from enq to deq.
// Backpressure: enq_rdy when empty or draining this cycle, so fill+drain sustains 1/cycle.
// Ports: clk, rst_n, enq_val/enq_rdy/enq_dat, deq_val/deq_rdy/deq_dat.
module dl_buf1 #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enq_val,
  output logic                enq_rdy,
  input  logic [NUM_BITS-1:0] enq_dat,
  output logic                deq_val,
  input  logic                deq_rdy,
  output logic [NUM_BITS-1:0] deq_dat
);

  logic                v;
  logic [NUM_BITS-1:0] d;

  // free when empty or when the held entry leaves this cycle
  assign enq_rdy = !v || deq_rdy;
  assign deq_val = v;
  assign deq_dat = d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (enq_val && enq_rdy) begin
        // a fill wins over a same-cycle drain: entry stays valid with new data
        v <= 1'b1;
        d <= enq_dat;
      end else if (deq_rdy) begin
        v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dl_demux8_buf.sv
// 1-to-8 stream demux steering by in_dest into one buffered entry per port; drops to disabled ports.
// Latency: 1 cycle from accepted input to out_val/out_msg of the destination port.
// Backpressure: in_rdy follows the destination entry's free state; drop path is always ready.
// Ports: clk, rst_n, port_en (per-port enable), drop_cnt (saturating), bus (slave stream bundle).
module dl_demux8_buf
  import dl_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DL_NUM_PORTS-1:0] port_en,
  output logic [CNT_BITS-1:0]     drop_cnt,
  dl_demux8_buf_if.slave          bus
);

  logic                    dest_en;
  logic                    drop_fire;
  logic [DL_NUM_PORTS-1:0] enq_val;
  logic [DL_NUM_PORTS-1:0] free;
  logic [DL_NUM_PORTS-1:0] val_q;
  logic [NUM_BITS-1:0]     dat_q [DL_NUM_PORTS];

  // in_rdy depends only on dest/enable/entry state, never on in_val
  assign dest_en    = port_en[bus.in_dest];
  assign bus.in_rdy = dest_en ? free[bus.in_dest] : 1'b1;
  assign drop_fire  = bus.in_val && !dest_en;

  always_comb begin
    enq_val = '0;
    for (int i = 0; i < DL_NUM_PORTS; i++) begin
      enq_val[i] = bus.in_val && dest_en && (bus.in_dest == dl_port_id_t'(i));
    end
  end

  for (genvar g = 0; g < DL_NUM_PORTS; g++) begin : g_port
    dl_buf1 #(
      .NUM_BITS (NUM_BITS)
    ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .enq_val (enq_val[g]),
      .enq_rdy (free[g]),
      .enq_dat (bus.in_msg),
      .deq_val (val_q[g]),
      .deq_rdy (bus.out_rdy[g]),
      .deq_dat (dat_q[g])
    );
  end

  assign bus.out_val = val_q;

  always_comb begin
    bus.out_msg = '0;
    for (int i = 0; i < DL_NUM_PORTS; i++) begin
      bus.out_msg[i*NUM_BITS +: NUM_BITS] = dat_q[i];
    end
  end

  // saturating drop counter: holds at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_fire && (drop_cnt != {CNT_BITS{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_dl_demux8_buf.sv
module tb_dl_demux8_buf;
  import dl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  port_en;
  logic [7:0]  port_en2;
  logic [15:0] drop_cnt;
  logic [1:0]  drop2;

  int n_chk = 0;
  int n_err = 0;

  dl_demux8_buf_if #(.NUM_BITS(32)) bus ();
  dl_demux8_buf_if #(.NUM_BITS(32)) bus2 ();

  dl_demux8_buf #(.NUM_BITS(32), .CNT_BITS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .port_en  (port_en),
    .drop_cnt (drop_cnt),
    .bus      (bus)
  );

  dl_demux8_buf #(.NUM_BITS(32), .CNT_BITS(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .port_en  (port_en2),
    .drop_cnt (drop2),
    .bus      (bus2)
  );

  always #5 clk = ~clk;

  // scoreboard: per-port queue of expected messages, plus expected drop counts
  logic [31:0] q [8][$];
  int          exp_drop  = 0;
  int          exp_drop2 = 0;
  bit          acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check at negedge against the scoreboard, advance the scoreboard, step to posedge+1.
  task automatic cyc();
    logic [2:0] dst;
    logic [7:0] ev;
    bit         erdy;
    @(negedge clk);
    acc = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) q[i].delete();
      exp_drop  = 0;
      exp_drop2 = 0;
      check("rst_out_val", bus.out_val, 8'h00);
      check("rst_drop", drop_cnt, 0);
    end else begin
      dst  = bus.in_dest;
      erdy = !port_en[dst] || (q[dst].size() == 0) || bus.out_rdy[dst];
      check("in_rdy", bus.in_rdy, erdy);
      ev = '0;
      for (int i = 0; i < 8; i++) begin
        ev[i] = (q[i].size() != 0);
        if (q[i].size() != 0)
          check($sformatf("slice%0d", i), bus.out_msg[i*32 +: 32], q[i][0]);
      end
      check("out_val", bus.out_val, ev);
      check("drop_cnt", drop_cnt, exp_drop);
      check("drop_cnt2", drop2, exp_drop2);
      for (int i = 0; i < 8; i++)
        if (q[i].size() != 0 && bus.out_rdy[i]) void'(q[i].pop_front());
      if (bus.in_val && erdy) begin
        acc = 1'b1;
        if (port_en[dst]) q[dst].push_back(bus.in_msg);
        else if (exp_drop < 65535) exp_drop++;
      end
      if (bus2.in_val && exp_drop2 < 3) exp_drop2++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int dst, input logic [31:0] m);
    bus.in_val  = 1'b1;
    bus.in_dest = dst[2:0];
    bus.in_msg  = m;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cyc();
    if (!acc) check("send_timeout", 0, 1);
    bus.in_val = 1'b0;
  endtask

  initial begin
    bus.in_val   = 1'b1;
    bus.in_dest  = 3'd3;
    bus.in_msg   = 32'hDEAD_BEEF;
    bus.out_rdy  = 8'h00;
    bus2.in_val  = 1'b0;
    bus2.in_dest = 3'd0;
    bus2.in_msg  = 32'h0;
    bus2.out_rdy = 8'hFF;
    port_en      = 8'hFF;
    port_en2     = 8'h00;
    #1 rst_n = 1'b0;

    // reset held with in_val high: nothing may be accepted
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.in_val = 1'b0;
    send(3, 32'hA5A5_0003);
    check("first_val", bus.out_val, 8'h08);
    check("first_slice3", bus.out_msg[3*32 +: 32], 32'hA5A5_0003);
    bus.out_rdy = 8'hFF;
    cyc();
    bus.out_rdy = 8'h00;

    // backpressure on port 5, then drain+fill in one cycle
    send(5, 32'h5555_000A);
    bus.in_val  = 1'b1;
    bus.in_dest = 3'd5;
    bus.in_msg  = 32'h5555_000B;
    cyc();
    check("bp_held_rdy", bus.in_rdy, 1'b0);
    bus.out_rdy[5] = 1'b1;
    cyc();
    bus.in_val  = 1'b0;
    bus.out_rdy = 8'h00;
    check("bp_slice5", bus.out_msg[5*32 +: 32], 32'h5555_000B);
    check("bp_val", bus.out_val, 8'h20);
    cyc();
    bus.out_rdy = 8'hFF;
    cyc();

    // back-to-back stream across all ports
    for (int i = 0; i < 16; i++) begin
      bus.in_val  = 1'b1;
      bus.in_dest = 3'(i % 8);
      bus.in_msg  = 32'h0000_0100 + 32'(i);
      cyc();
    end
    bus.in_val = 1'b0;
    cyc();
    cyc();

    // drops to a disabled port 0
    port_en = 8'hFE;
    for (int i = 0; i < 3; i++) send(0, 32'hD000_0000 + 32'(i));
    check("drop_three", drop_cnt, 16'd3);
    check("drop_port0_empty", bus.out_val[0], 1'b0);
    port_en = 8'hFF;

    // 2-bit counter saturates at 3
    bus2.in_val = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    bus2.in_val = 1'b0;
    check("drop2_sat", drop2, 2'd3);

    // independence of ports 1 and 6
    bus.out_rdy = 8'h00;
    send(1, 32'h1111_0001);
    send(6, 32'h6666_0001);
    check("ind_val42", bus.out_val, 8'h42);
    bus.out_rdy = 8'h02;
    cyc();
    check("ind_val40", bus.out_val, 8'h40);
    send(1, 32'h1111_0002);
    check("ind_port6_held", bus.out_val, 8'h42);
    check("ind_slice6", bus.out_msg[6*32 +: 32], 32'h6666_0001);
    bus.out_rdy = 8'hFF;
    cyc();

    // disabling a port with a live entry does not flush it
    bus.out_rdy = 8'h00;
    send(2, 32'h2222_0002);
    port_en[2] = 1'b0;
    cyc();
    check("dis_keep", bus.out_val[2], 1'b1);
    bus.out_rdy = 8'hFF;
    cyc();
    port_en = 8'hFF;
    cyc();

    // mid-operation asynchronous reset
    bus.out_rdy = 8'h00;
    send(0, 32'h0000_00A0);
    send(2, 32'h0000_00A2);
    send(4, 32'h0000_00A4);
    send(7, 32'h0000_00A7);
    check("mid_val_full", bus.out_val, 8'h95);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_val", bus.out_val, 8'h00);
    check("mid_async_msg", bus.out_msg, 256'h0);
    cyc();
    rst_n = 1'b1;
    bus.out_rdy = 8'hFF;
    cyc();
    cyc();
    send(4, 32'h4444_0004);
    check("post_rst_val", bus.out_val, 8'h10);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
